dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer for the single-ported data memory. It accepts load/store requests from two requesters: port 0 is the CPU load/store unit, port 1 is the debug/DMA master. It grants one request at a time, drives the data-memory read/write controls for exactly one cycle, and returns a registered response with a valid/ready handshake. It sits between the requesters and the data memory, which it owns outright; no other block drives the memory controls.

## Interface
Parameters:
- ADDR_W, 32, byte-address width (the memory indexes words with addr[ADDR_W-1:2])
- DATA_W, 32, data word width

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ip_req  input  2  per-port request; bit i = port i
- ip_we  input  2  per-port write enable (1 = store, 0 = load)
- ip_addr  input  2*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W]
- ip_wdata  input  2*DATA_W  packed store data
- ip_rsp_ready  input  2  per-port response accept
- op_gnt  output  2  one-hot grant pulse
- op_rsp_valid  output  2  one-hot response valid
- op_rdata  output  DATA_W  load data, shared by both ports; qualify with op_rsp_valid
- op_mem_read  output  1  data-memory read enable
- op_mem_write  output  1  data-memory write enable
- op_mem_addr  output  ADDR_W  data-memory address
- op_mem_wdata  output  DATA_W  data-memory write data
- ip_mem_rdata  input  DATA_W  data-memory combinational read data

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - if any ip_req is set, pick a winner (see Configuration).
  - Latch the winner's addr, wdata, we and index into registers.
  - Go to WRITE if we=1, else to READ.
- READ / WRITE (exactly one cycle):
  - op_gnt[winner]=1.
  - op_mem_addr and op_mem_wdata come from the latched registers.
  - op_mem_read=1 in READ; op_mem_write=1 in WRITE.
  - READ captures ip_mem_rdata into the rdata register at the closing edge. WRITE loads 0 into it.
  - Next state: RESP.
- RESP:
  - op_rsp_valid[winner]=1 and op_rdata = the rdata register, both held stable until ip_rsp_ready[winner]=1.
  - On that edge go to IDLE.
- Requests are sampled only in IDLE. A requester holds req/we/addr/wdata stable until it sees op_gnt, then deasserts req within two cycles, or else it is accepted again.
- The non-winning request stays pending and is considered at the next IDLE.
- ip_rsp_ready of the non-winning port is ignored.
- Memory controls are decoded from registered state and registered fields only. There is no combinational path from ip_* to op_mem_*.

## Timing
- Reset values:
  - state=IDLE
  - op_gnt=0, op_rsp_valid=0, op_rdata=0
  - op_mem_read=0, op_mem_write=0, op_mem_addr=0, op_mem_wdata=0
  - last-grant pointer=1
- Access sequence:
  - request sampled at edge N
  - op_gnt and the memory access occupy cycle N+1
  - the write commits at edge N+2
  - op_rsp_valid is asserted from cycle N+2
- With ip_rsp_ready held high, RESP lasts one cycle. Minimum spacing is three cycles per access.
- RESP stall: any number of cycles. op_rdata and op_rsp_valid do not change.
- Reset asserted in any state: immediate return to reset values.
  - A WRITE interrupted before its closing edge does not commit.
  - No response is issued for the aborted access.
- Address bits [1:0] are passed through unchanged. The arbiter does not check alignment.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - When both ports request in IDLE, grant the port that is not the last-grant pointer.
  - The pointer updates to the winner on every grant.
  - The first contention after reset goes to port 0.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins.
  - The pointer register is not built.

## Structure
- Package dmem_arb_pkg holds:
  - the state encoding localparams (IDLE=2'd0, READ=2'd1, WRITE=2'd2, RESP=2'd3)
  - the port index constants (PORT_CPU=0, PORT_DBG=1)
- One sub-module, dmem_arb_pick: a combinational 2-request picker.
  - Inputs: req[1:0], last.
  - Output: one-hot winner.
  - Contains the DMEM_ARB_RR_EN selection.

## Test plan
- Port 0 store addr 0x10 data 0xDEADBEEF, then load 0x10:
  - op_gnt[0] pulses one cycle after each request.
  - op_mem_write is high for exactly one cycle.
  - The load returns op_rdata=0xDEADBEEF with op_rsp_valid[0] two cycles after the request.
- Both ports load simultaneously, repeated 4 times, with the macro defined:
  - grants alternate 0,1,0,1
  - without the macro: all grants go to port 0 while it keeps requesting.
- ip_rsp_ready[1] held low for 5 cycles during a port 1 load:
  - op_rsp_valid[1] and op_rdata stay stable for 5 cycles.
  - A pending port 0 request is not granted until after the handshake.
- rst_n pulsed low during WRITE of addr 0x20 data 0x1:
  - all outputs go to 0 asynchronously.
  - A later load of 0x20 returns the pre-reset contents.
- Back-to-back port 0 loads with ip_rsp_ready high:
  - a new grant every 3 cycles.
  - op_mem_read is never asserted in IDLE or RESP.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and port indices.
// Helper port_onehot turns a latched port index into a grant/valid vector.
package dmem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational 2-request picker; DMEM_ARB_RR_EN selects round-robin,
// otherwise port 0 has fixed priority and the last-grant input is ignored.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] winner
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        winner = 2'b00;
        if (req[PORT_CPU] && req[PORT_DBG]) begin
            // Contention: favour the port that did not win last time
            winner = port_onehot(~last);
        end else if (req[PORT_CPU]) begin
            winner = 2'b01;
        end else if (req[PORT_DBG]) begin
            winner = 2'b10;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        winner = 2'b00;
        if (req[PORT_CPU]) begin
            winner = 2'b01;
        end else if (req[PORT_DBG]) begin
            winner = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-cycle access sequencer for the data memory.
// Build option DMEM_ARB_RR_EN: round-robin arbitration instead of port-0 priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            ip_req,
    input  logic [1:0]            ip_we,
    input  logic [2*ADDR_W-1:0]   ip_addr,
    input  logic [2*DATA_W-1:0]   ip_wdata,
    input  logic [1:0]            ip_rsp_ready,
    output logic [1:0]            op_gnt,
    output logic [1:0]            op_rsp_valid,
    output logic [DATA_W-1:0]     op_rdata,
    output logic                  op_mem_read,
    output logic                  op_mem_write,
    output logic [ADDR_W-1:0]     op_mem_addr,
    output logic [DATA_W-1:0]     op_mem_wdata,
    input  logic [DATA_W-1:0]     ip_mem_rdata
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        win;
    logic              win_idx;
    logic              take;
    logic              last;
    logic              sel;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    assign take = (state == IDLE) && (|ip_req);

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= win_idx;
        end
    end

    assign last = last_q;
`else
    assign last = 1'b1;
`endif

    dmem_arb_pick u_pick (
        .req    (ip_req),
        .last   (last),
        .winner (win)
    );

    assign win_idx = win[PORT_DBG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (|ip_req) begin
                    state_nxt = ip_we[win_idx] ? WRITE : READ;
                end
            end
            READ:  state_nxt = RESP;
            WRITE: state_nxt = RESP;
            RESP: begin
                if (ip_rsp_ready[sel]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured once in IDLE; memory controls use only these
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (take) begin
                sel     <= win_idx;
                we_q    <= ip_we[win_idx];
                addr_q  <= win_idx ? ip_addr[2*ADDR_W-1:ADDR_W]
                                   : ip_addr[ADDR_W-1:0];
                wdata_q <= win_idx ? ip_wdata[2*DATA_W-1:DATA_W]
                                   : ip_wdata[DATA_W-1:0];
            end
            if (state == READ) begin
                rdata_q <= ip_mem_rdata;
            end else if (state == WRITE) begin
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        op_gnt       = 2'b00;
        op_rsp_valid = 2'b00;
        op_mem_read  = 1'b0;
        op_mem_write = 1'b0;
        unique case (1'b1)
            (state == READ): begin
                op_gnt      = port_onehot(sel);
                op_mem_read = ~we_q;
            end
            (state == WRITE): begin
                op_gnt       = port_onehot(sel);
                op_mem_write = we_q;
            end
            (state == RESP): begin
                op_rsp_valid = port_onehot(sel);
            end
            default: ;
        endcase
    end

    assign op_mem_addr  = addr_q;
    assign op_mem_wdata = wdata_q;
    assign op_rdata     = rdata_q;

endmodule
